instruction_fetch_stage: RTL and testbench

INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

---
 rtl/instruction_fetch_stage_pkg.sv | 21 ++
 rtl/instruction_fetch_stage_if_id.sv | 37 +++
 rtl/instruction_fetch_stage.sv | 147 ++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_stage_pkg;

    // RUN: a fetch request is outstanding.
    // HOLD: a fetched word is parked in the buffer while decode is stalled.
    // DROP: an outstanding request must complete but its data is discarded.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;

    // Redirect targets are word addresses; the two low bits are ignored.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id.sv
// IF/ID pipeline register. flush wins over load, load wins over hold;
// with no control asserted the register emits a bubble.
module if_id_register
    import instruction_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic        hold,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        valid
);

    // Register update: clear on flush/bubble, capture on load, freeze on hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= NOP;
            pc    <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pc    <= pc_in;
            valid <= 1'b1;
        end else if (!hold) begin
            instr <= NOP;
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: issues word fetches over a req/ack handshake and
// feeds the IF/ID register, handling stalls and taken redirects.
// Handshake: imem_req/imem_addr are held stable until imem_ack is seen in a
// cycle where imem_req is 1; that ack completes the transfer with imem_rdata.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        JumpRegister,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] JumpRegTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output logic [1:0]  dbg_state
);

    fetch_state_t state_q, state_nxt;
    logic [31:0]  pc_q, pc_nxt;
    logic [31:0]  tgt_q, tgt_nxt;
    logic [31:0]  buf_instr_q, buf_instr_nxt;
    logic [31:0]  buf_pc_q, buf_pc_nxt;
    logic [31:0]  pc_inc;
    logic [31:0]  target;
    logic         redirect;
    logic         ifid_load, ifid_flush, ifid_hold;
    logic [31:0]  ifid_instr, ifid_pc;

    assign pc_inc   = pc_q + PC_INC;
    // A redirect only counts when decode holds a real instruction and is moving.
    assign redirect = valid_out && !Stall && (Branch || Jump || JumpRegister);
    assign target   = word_align(JumpRegister ? JumpRegTarget :
                                 Jump         ? JumpTarget    : BranchTarget);

    // Gated by Reset directly so no request is visible while reset is held.
    assign imem_req  = Reset && (state_q != ST_HOLD);
    assign imem_addr = pc_q;
    assign dbg_state = state_q;

    // State, fetch address, latched target and stall buffer.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            tgt_q       <= '0;
            buf_instr_q <= NOP;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_nxt;
            pc_q        <= pc_nxt;
            tgt_q       <= tgt_nxt;
            buf_instr_q <= buf_instr_nxt;
            buf_pc_q    <= buf_pc_nxt;
        end
    end

    // Next-state and IF/ID control decode.
    always_comb begin
        state_nxt     = state_q;
        pc_nxt        = pc_q;
        tgt_nxt       = tgt_q;
        buf_instr_nxt = buf_instr_q;
        buf_pc_nxt    = buf_pc_q;
        ifid_load     = 1'b0;
        ifid_flush    = 1'b0;
        ifid_hold     = 1'b0;
        ifid_instr    = imem_rdata;
        ifid_pc       = pc_inc;
        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    ifid_flush = 1'b1;
                    if (imem_ack) begin
                        pc_nxt = target;
                    end else begin
                        tgt_nxt   = target;
                        state_nxt = ST_DROP;
                    end
                end else if (imem_ack && !Stall) begin
                    ifid_load = 1'b1;
                    pc_nxt    = pc_inc;
                end else if (imem_ack) begin
                    buf_instr_nxt = imem_rdata;
                    buf_pc_nxt    = pc_inc;
                    pc_nxt        = pc_inc;
                    ifid_hold     = 1'b1;
                    state_nxt     = ST_HOLD;
                end else if (Stall) begin
                    ifid_hold = 1'b1;
                end else begin
                    ifid_flush = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    ifid_flush    = 1'b1;
                    pc_nxt        = target;
                    buf_instr_nxt = NOP;
                    buf_pc_nxt    = '0;
                    state_nxt     = ST_RUN;
                end else if (!Stall) begin
                    ifid_load  = 1'b1;
                    ifid_instr = buf_instr_q;
                    ifid_pc    = buf_pc_q;
                    state_nxt  = ST_RUN;
                end else begin
                    ifid_hold = 1'b1;
                end
            end
            ST_DROP: begin
                ifid_flush = 1'b1;
                if (imem_ack) begin
                    pc_nxt    = tgt_q;
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    if_id_register u_if_id (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (ifid_load),
        .flush    (ifid_flush),
        .hold     (ifid_hold),
        .instr_in (ifid_instr),
        .pc_in    (ifid_pc),
        .instr    (instr_out),
        .pc       (pc_out),
        .valid    (valid_out)
    );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: sequential fetch, wait states,
// stall hold, redirect priority, dropped requests, reset mid-drop, PC wrap.
module tb_instruction_fetch_stage;
    import instruction_fetch_stage_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Stall = 1'b0;
    logic        Branch = 1'b0;
    logic        Jump = 1'b0;
    logic        JumpRegister = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic [31:0] JumpTarget = '0;
    logic [31:0] JumpRegTarget = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // clock / reset block
    always #5 Clk = ~Clk;

    // Memory model: each word is its address xor a fixed pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    instruction_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Stall         (Stall),
        .Branch        (Branch),
        .Jump          (Jump),
        .JumpRegister  (JumpRegister),
        .BranchTarget  (BranchTarget),
        .JumpTarget    (JumpTarget),
        .JumpRegTarget (JumpRegTarget),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .valid_out     (valid_out),
        .dbg_state     (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, "_valid"}, {31'd0, valid_out}, {31'd0, v});
        chk({tag, "_pc"}, pc_out, pc);
        chk({tag, "_instr"}, instr_out, ins);
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
        chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, r});
        chk({tag, "_addr"}, imem_addr, a);
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // reset state
        #2;
        chk_ifid("rst", 1'b0, 32'h0, NOP);
        chk_req("rst", 1'b0, 32'h0);
        chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_RUN});
        next_cycle();
        next_cycle();

        // release, ack every cycle
        next_cycle(); Reset = 1'b1; imem_ack = 1'b1; #1;
        chk_req("c1", 1'b1, 32'h0);
        chk("c1_valid", {31'd0, valid_out}, 32'd0);
        next_cycle(); #1;
        chk_req("c2", 1'b1, 32'h4);
        chk_ifid("c2", 1'b1, 32'h4, mem_word(32'h0));
        next_cycle(); #1;
        chk_req("c3", 1'b1, 32'h8);
        chk_ifid("c3", 1'b1, 32'h8, mem_word(32'h4));
        next_cycle(); #1;
        chk_ifid("c4", 1'b1, 32'hC, mem_word(32'h8));

        // two wait cycles at 0x10
        next_cycle(); imem_ack = 1'b0; #1;
        chk_req("w0", 1'b1, 32'h10);
        chk_ifid("w0", 1'b1, 32'h10, mem_word(32'hC));
        next_cycle(); #1;
        chk_req("w1", 1'b1, 32'h10);
        chk_ifid("w1", 1'b0, 32'h10, NOP);
        next_cycle(); imem_ack = 1'b1; #1;
        chk_req("w2", 1'b1, 32'h10);
        chk("w2_valid", {31'd0, valid_out}, 32'd0);
        next_cycle(); #1;
        chk_ifid("w3", 1'b1, 32'h14, mem_word(32'h10));
        next_cycle(); #1;
        next_cycle(); #1;
        chk_req("s_pre", 1'b1, 32'h1C);

        // stall with ack at 0x20, held 3 cycles
        next_cycle(); Stall = 1'b1; #1;
        chk_req("s0", 1'b1, 32'h20);
        chk_ifid("s0", 1'b1, 32'h20, mem_word(32'h1C));
        next_cycle(); imem_ack = 1'b0; #1;
        chk_req("s1", 1'b0, 32'h24);
        chk_ifid("s1", 1'b1, 32'h20, mem_word(32'h1C));
        chk("s1_state", {30'd0, dbg_state}, {30'd0, ST_HOLD});
        next_cycle(); #1;
        chk_ifid("s2", 1'b1, 32'h20, mem_word(32'h1C));
        next_cycle(); Stall = 1'b0; #1;
        chk_req("s3", 1'b0, 32'h24);
        chk_ifid("s3", 1'b1, 32'h20, mem_word(32'h1C));
        next_cycle(); #1;
        chk_ifid("s4", 1'b1, 32'h24, mem_word(32'h20));
        chk_req("s4", 1'b1, 32'h24);

        // jump beats branch, with ack in the same cycle
        Jump = 1'b1; JumpTarget = 32'h0040_0003;
        Branch = 1'b1; BranchTarget = 32'h0000_0100;
        imem_ack = 1'b1;
        next_cycle(); Jump = 1'b0; Branch = 1'b0; #1;
        chk_req("j1", 1'b1, 32'h0040_0000);
        chk_ifid("j1", 1'b0, 32'h24, NOP);
        next_cycle(); #1;
        chk_ifid("j2", 1'b1, 32'h0040_0004, mem_word(32'h0040_0000));

        // branch with no ack: request dropped
        Branch = 1'b1; BranchTarget = 32'h0000_0100; imem_ack = 1'b0;
        next_cycle(); Branch = 1'b0; #1;
        chk_req("d1", 1'b1, 32'h0040_0004);
        chk("d1_state", {30'd0, dbg_state}, {30'd0, ST_DROP});
        chk("d1_valid", {31'd0, valid_out}, 32'd0);
        next_cycle(); imem_ack = 1'b1; #1;
        chk_req("d2", 1'b1, 32'h0040_0004);
        chk("d2_valid", {31'd0, valid_out}, 32'd0);
        next_cycle(); #1;
        chk_req("d3", 1'b1, 32'h100);
        chk("d3_valid", {31'd0, valid_out}, 32'd0);
        next_cycle(); #1;
        chk_ifid("d4", 1'b1, 32'h104, mem_word(32'h100));

        // enter DROP again, then reset mid-transaction
        Branch = 1'b1; BranchTarget = 32'h0000_0200; imem_ack = 1'b0;
        next_cycle(); Branch = 1'b0; #1;
        chk("r0_state", {30'd0, dbg_state}, {30'd0, ST_DROP});
        Reset = 1'b0; #1;
        chk_req("r1", 1'b0, 32'h0);
        chk("r1_state", {30'd0, dbg_state}, {30'd0, ST_RUN});
        chk_ifid("r1", 1'b0, 32'h0, NOP);
        next_cycle();
        next_cycle(); Reset = 1'b1; imem_ack = 1'b1; #1;
        chk_req("r2", 1'b1, 32'h0);

        // jump-register beats jump; target aligned to 0xFFFF_FFFC, then wrap
        next_cycle();
        JumpRegister = 1'b1; JumpRegTarget = 32'hFFFF_FFFE;
        Jump = 1'b1; JumpTarget = 32'h0000_0300;
        #1;
        chk_ifid("x1", 1'b1, 32'h4, mem_word(32'h0));
        next_cycle(); JumpRegister = 1'b0; Jump = 1'b0; #1;
        chk_req("x2", 1'b1, 32'hFFFF_FFFC);
        chk("x2_valid", {31'd0, valid_out}, 32'd0);
        next_cycle(); #1;
        chk_req("x3", 1'b1, 32'h0);
        chk_ifid("x3", 1'b1, 32'h0, mem_word(32'hFFFF_FFFC));

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
